// File: rtl/pc_sched.sv
// Fetch PC scheduler: picks the next fetch address from exception, eret, branch or
// sequential flow, and holds taken branches until instruction memory accepts the delay slot.
module pc_sched (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        imem_ready,
    input  logic        req,
    input  logic        eret,
    input  logic [31:0] epc,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        flush_d,
    output logic [1:0]  state,
    output logic [7:0]  exc_cnt,
    output logic        pc_adel
);

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        EXC  = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
    localparam logic [31:0] PC_STEP  = 32'd4;
    localparam logic [7:0]  CNT_MAX  = 8'd255;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        accept_s;
    logic        take_req_s;
    logic        flush_s;

    assign pc_valid = (state_q == RUN) || (state_q == HOLD);
    assign accept_s = pc_valid & imem_ready & ~stall;

    // Next-state, next-PC and redirect decode; req and eret override everything in RUN/HOLD.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        flush_s    = 1'b0;
        take_req_s = 1'b0;
        case (state_q)
            INIT: begin
                state_d = RUN;
            end
            RUN, HOLD: begin
                if (req) begin
                    pc_d       = EXC_VEC;
                    pend_d     = 32'd0;
                    flush_s    = 1'b1;
                    take_req_s = 1'b1;
                    state_d    = EXC;
                end else if (eret) begin
                    pc_d    = epc + PC_STEP;
                    pend_d  = 32'd0;
                    flush_s = 1'b1;
                    state_d = RUN;
                end else if (state_q == HOLD) begin
                    if (accept_s) begin
                        pc_d    = pend_q;
                        state_d = RUN;
                    end else begin
                        pc_d = pc_q;
                    end
                end else if (br_valid && !stall) begin
                    // Delay slot must be fetched before jumping; park the target if it isn't taken now.
                    if (accept_s) begin
                        pc_d = br_target;
                    end else begin
                        pend_d  = br_target;
                        state_d = HOLD;
                    end
                end else if (accept_s) begin
                    pc_d = pc_q + PC_STEP;
                end else begin
                    pc_d = pc_q;
                end
            end
            EXC: begin
                if (req) begin
                    pc_d       = EXC_VEC;
                    take_req_s = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase

        if (take_req_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State, PC, pending target and exception counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= INIT;
            pc_q    <= RESET_PC;
            pend_q  <= 32'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc      = pc_q;
    assign state   = state_q;
    assign exc_cnt = cnt_q;
    assign flush_d = flush_s;
    assign pc_adel = |pc_q[1:0];

endmodule
